// File: rtl/gate_sweep_ctrl_pkg.sv
// Shared definitions for the gate sweep controller: FSM state encoding and
// the expected truth tables of the common two-input gates.
// Truth-table bit i is the expected y for the input vector {a,b} = i.
package gate_sweep_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam logic [3:0] TT_AND  = 4'b1000;
    localparam logic [3:0] TT_OR   = 4'b1110;
    localparam logic [3:0] TT_XOR  = 4'b0110;
    localparam logic [3:0] TT_NAND = 4'b0111;
    localparam logic [3:0] TT_NOR  = 4'b0001;

endpackage

// File: rtl/gate_sweep_ctrl_settle_timer.sv
// 8-bit settle down-counter. A load takes precedence over counting; the
// counter stops at zero. 'expiring' flags the last count before zero so the
// sequencer can leave its wait state on the same edge the count reaches zero.
module settle_timer (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [7:0] load_val,
    input  logic       enable,
    output logic       expired,
    output logic       expiring
);

    logic [7:0] count_q;
    logic [7:0] count_d;

    // Next count: reload, decrement while enabled, or hold.
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (enable && (count_q != 8'd0)) begin
            count_d = count_q - 8'd1;
        end
    end

    // Count register, cleared by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= 8'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired  = (count_q == 8'd0);
    assign expiring = (count_q == 8'd1);

endmodule

// File: rtl/gate_sweep_ctrl.sv
// Sweep sequencer for a two-input gate under test. Applies {a,b} = 0..3 in
// turn, holds each vector SETTLE_CYCLES edges, samples y on the last of those
// edges and compares it with EXP_TT. Reports a per-vector fail mask, a pass
// flag and a one-cycle done pulse. Every output comes straight from a flop.
module gate_sweep_ctrl
    import gate_sweep_ctrl_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter logic [3:0]  EXP_TT        = TT_AND
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    input  logic       y,
    output logic       a,
    output logic       b,
    output logic [1:0] vec_idx,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] fail_mask
);

    // The counter holds S-1 when a vector is applied, so the SETTLE state
    // covers S-1 edges and SAMPLE the final one. With S=1 there is no wait.
    localparam logic [7:0] LOAD_VAL    = 8'(SETTLE_CYCLES - 1);
    localparam state_t     FIRST_STATE = (SETTLE_CYCLES == 1) ? ST_SAMPLE : ST_SETTLE;

    state_t     state_q, state_d;
    logic [1:0] vec_idx_q, vec_idx_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       pass_q, pass_d;
    logic [3:0] fail_mask_q, fail_mask_d;

    logic tmr_load;
    logic tmr_enable;
    logic tmr_expired;
    logic tmr_expiring;

    settle_timer u_settle_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (LOAD_VAL),
        .enable   (tmr_enable),
        .expired  (tmr_expired),
        .expiring (tmr_expiring)
    );

    // Next-state and output computation; abort beats a sample on the same edge.
    always_comb begin
        state_d     = state_q;
        vec_idx_d   = vec_idx_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        pass_d      = pass_q;
        fail_mask_d = fail_mask_q;
        tmr_load    = 1'b0;
        tmr_enable  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    vec_idx_d   = 2'd0;
                    busy_d      = 1'b1;
                    fail_mask_d = 4'b0000;
                    pass_d      = 1'b0;
                    tmr_load    = 1'b1;
                    state_d     = FIRST_STATE;
                end
            end

            ST_SETTLE: begin
                if (abort) begin
                    vec_idx_d   = 2'd0;
                    busy_d      = 1'b0;
                    fail_mask_d = 4'b0000;
                    pass_d      = 1'b0;
                    state_d     = ST_IDLE;
                end else begin
                    tmr_enable = 1'b1;
                    // A zero count here is never expected; leaving anyway
                    // guarantees the sweep cannot stall.
                    if (tmr_expiring || tmr_expired) begin
                        state_d = ST_SAMPLE;
                    end
                end
            end

            ST_SAMPLE: begin
                if (abort) begin
                    vec_idx_d   = 2'd0;
                    busy_d      = 1'b0;
                    fail_mask_d = 4'b0000;
                    pass_d      = 1'b0;
                    state_d     = ST_IDLE;
                end else begin
                    fail_mask_d[vec_idx_q] = (y != EXP_TT[vec_idx_q]);
                    if (vec_idx_q != 2'd3) begin
                        vec_idx_d = vec_idx_q + 2'd1;
                        tmr_load  = 1'b1;
                        state_d   = FIRST_STATE;
                    end else begin
                        vec_idx_d = 2'd0;
                        busy_d    = 1'b0;
                        done_d    = 1'b1;
                        pass_d    = (fail_mask_d == 4'b0000);
                        state_d   = ST_DONE;
                    end
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers, cleared immediately by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            vec_idx_q   <= 2'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            fail_mask_q <= 4'b0000;
        end else begin
            state_q     <= state_d;
            vec_idx_q   <= vec_idx_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            fail_mask_q <= fail_mask_d;
        end
    end

    assign a         = vec_idx_q[1];
    assign b         = vec_idx_q[0];
    assign vec_idx   = vec_idx_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign fail_mask = fail_mask_q;

endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// Bench for gate_sweep_ctrl. Two instances: dut0 with S=4 checking AND and
// dut1 with S=1 checking XOR. The gate under test is a truth-table lookup on
// {a,b}. Every cycle of every sweep is compared with a timeline model derived
// from the sweep rules: vector k is applied at edge k*S after the start edge,
// sampled at edge (k+1)*S, done at edge 4*S, abort clears everything.
module tb_gate_sweep_ctrl;
    import gate_sweep_ctrl_pkg::*;

    typedef struct packed {
        logic       busy;
        logic       done;
        logic       pass;
        logic       a;
        logic       b;
        logic [1:0] vec;
        logic [3:0] fm;
    } obs_t;

    typedef struct {
        int         dut;
        logic [3:0] ytt;
        int         ab;
        int         xs;
        logic [3:0] exp_fm;
        logic       exp_pass;
    } vec_t;

    logic       clk;
    logic       rst_n;
    logic       start0, abort0, start1, abort1;
    logic [3:0] ytt0, ytt1;
    logic       y0, y1;
    logic       a0, b0, busy0, done0, pass0;
    logic       a1, b1, busy1, done1, pass1;
    logic [1:0] vec0, vec1;
    logic [3:0] fm0, fm1;
    obs_t       act0, act1;

    int nChecks = 0;
    int nFails  = 0;

    assign y0   = ytt0[{a0, b0}];
    assign y1   = ytt1[{a1, b1}];
    assign act0 = {busy0, done0, pass0, a0, b0, vec0, fm0};
    assign act1 = {busy1, done1, pass1, a1, b1, vec1, fm1};

    gate_sweep_ctrl #(.SETTLE_CYCLES(4), .EXP_TT(TT_AND)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .abort(abort0), .y(y0),
        .a(a0), .b(b0), .vec_idx(vec0), .busy(busy0), .done(done0),
        .pass(pass0), .fail_mask(fm0)
    );

    gate_sweep_ctrl #(.SETTLE_CYCLES(1), .EXP_TT(TT_XOR)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1), .y(y1),
        .a(a1), .b(b1), .vec_idx(vec1), .busy(busy1), .done(done1),
        .pass(pass1), .fail_mask(fm1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int settleOf(int d);
        return (d == 0) ? 4 : 1;
    endfunction

    function automatic logic [3:0] expTtOf(int d);
        return (d == 0) ? TT_AND : TT_XOR;
    endfunction

    function automatic obs_t getObs(int d);
        return (d == 0) ? act0 : act1;
    endfunction

    // Expected outputs after edge t of a sweep (t=0 is the start edge).
    function automatic obs_t model(int t, int s, logic [3:0] ytt, logic [3:0] ett, int ab);
        obs_t       o;
        logic [3:0] mism;
        o    = obs_t'(0);
        mism = ytt ^ ett;
        if (ab > 0 && ab <= 4 * s && t >= ab) begin
            return o;
        end
        if (t < 4 * s) begin
            o.busy = 1'b1;
            o.vec  = 2'(t / s);
            o.a    = o.vec[1];
            o.b    = o.vec[0];
            for (int k = 0; k < 4; k++) begin
                if ((k + 1) * s <= t) o.fm[k] = mism[k];
            end
        end else begin
            o.done = (t == 4 * s);
            o.fm   = mism;
            o.pass = (mism == 4'b0000);
        end
        return o;
    endfunction

    task automatic checkOutput(input string name, input obs_t act, input obs_t exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("[TB] FAIL %s: got busy=%b done=%b pass=%b a=%b b=%b vec=%0d fail_mask=%b, expected busy=%b done=%b pass=%b a=%b b=%b vec=%0d fail_mask=%b",
                     name, act.busy, act.done, act.pass, act.a, act.b, act.vec, act.fm,
                     exp.busy, exp.done, exp.pass, exp.a, exp.b, exp.vec, exp.fm);
        end
    endtask

    task automatic setInputs(input int d, input logic st, input logic ab);
        start0 = (d == 0) ? st : 1'b0;
        abort0 = (d == 0) ? ab : 1'b0;
        start1 = (d == 1) ? st : 1'b0;
        abort1 = (d == 1) ? ab : 1'b0;
    endtask

    // Runs one sweep on instance d, checking every cycle against the model.
    // ab: edge at which abort takes effect (-1 none); xs: edge of a stray start.
    task automatic applyStimulus(input int d, input logic [3:0] ytt, input int ab,
                                 input int xs, output logic [3:0] fmOut, output logic passOut);
        int   s;
        obs_t o;
        s = settleOf(d);
        if (d == 0) ytt0 = ytt; else ytt1 = ytt;
        @(negedge clk);
        setInputs(d, 1'b1, 1'b0);
        @(posedge clk);
        for (int t = 0; t <= 4 * s + 2; t++) begin
            @(negedge clk);
            checkOutput($sformatf("dut%0d tt=%b ab=%0d t=%0d", d, ytt, ab, t),
                        getObs(d), model(t, s, ytt, expTtOf(d), ab));
            setInputs(d, (ab < 0) && (t + 1 == xs), (t + 1 == ab));
        end
        setInputs(d, 1'b0, 1'b0);
        o       = getObs(d);
        fmOut   = o.fm;
        passOut = o.pass;
    endtask

    initial begin
        vec_t       table_v[6];
        logic [3:0] fmRes;
        logic       passRes;
        int         d, s, ab, xs;
        logic [3:0] ytt;

        // Directed sweeps with independently worked-out final results.
        table_v[0] = '{0, 4'b1000, -1,  2, 4'b0000, 1'b1};
        table_v[1] = '{0, 4'b0000, -1, -1, 4'b1000, 1'b0};
        table_v[2] = '{0, 4'b1111, -1, -1, 4'b0111, 1'b0};
        table_v[3] = '{1, 4'b0110, -1, -1, 4'b0000, 1'b1};
        table_v[4] = '{0, 4'b1000,  6, -1, 4'b0000, 1'b0};
        table_v[5] = '{1, 4'b1000, -1,  5, 4'b1110, 1'b0};

        rst_n = 1'b0;
        ytt0  = 4'b1000;
        ytt1  = 4'b0110;
        setInputs(0, 1'b0, 1'b0);
        #1;
        checkOutput("reset dut0", act0, obs_t'(0));
        checkOutput("reset dut1", act1, obs_t'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            applyStimulus(table_v[i].dut, table_v[i].ytt, table_v[i].ab, table_v[i].xs,
                          fmRes, passRes);
            checkOutput($sformatf("table row %0d final", i),
                        obs_t'({3'b000, passRes, 3'b000, 2'b00, fmRes}),
                        obs_t'({3'b000, table_v[i].exp_pass, 3'b000, 2'b00, table_v[i].exp_fm}));
        end

        // Reset asserted between edges in the middle of a settle period.
        ytt0 = 4'b1000;
        @(negedge clk);
        setInputs(0, 1'b1, 1'b0);
        @(posedge clk);
        @(negedge clk);
        setInputs(0, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("mid-sweep reset dut0", act0, obs_t'(0));
        checkOutput("mid-sweep reset dut1", act1, obs_t'(0));
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(0, 4'b1000, -1, -1, fmRes, passRes);
        checkOutput("sweep after reset final",
                    obs_t'({3'b000, passRes, 3'b000, 2'b00, fmRes}),
                    obs_t'({3'b000, 1'b1, 3'b000, 2'b00, 4'b0000}));

        // Random gates, abort points and stray starts.
        for (int i = 0; i < 24; i++) begin
            d   = int'($urandom_range(0, 1));
            s   = settleOf(d);
            ytt = 4'($urandom);
            ab  = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 4 * s)) : -1;
            xs  = (ab < 0 && $urandom_range(0, 1) == 1) ? int'($urandom_range(1, 4 * s + 1)) : -1;
            applyStimulus(d, ytt, ab, xs, fmRes, passRes);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
